// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
// Contents: FSM state encoding, header magic nibble, helpers that slice one
// requester byte out of the packed request bus and build the header byte.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_XFER    = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_WAIT_LO = 3'd4
    } arb_state_t;

    localparam logic [3:0]  HDR_MAGIC        = 4'hA;
    localparam int unsigned MAX_REQ          = 8;
    localparam int unsigned MAX_PAYLOAD_BITS = 16;
    localparam int unsigned MAX_BUS_W        = MAX_REQ * MAX_PAYLOAD_BITS;

    // Byte of requester idx from a packed bus (requester i at [i*pb +: pb]).
    function automatic logic [MAX_PAYLOAD_BITS-1:0] req_slice(
        input logic [MAX_BUS_W-1:0] bus,
        input logic [2:0]           idx,
        input int unsigned          payload_bits
    );
        return MAX_PAYLOAD_BITS'(bus >> (32'(idx) * payload_bits));
    endfunction

    // Header byte announcing which requester owns the following message.
    function automatic logic [7:0] hdr_byte(input logic [2:0] gid);
        return {HDR_MAGIC, 1'b0, gid};
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin pick: first asserted request strictly after the pointer,
// wrapping, so the pointer position itself has the lowest priority.
// Ports:
//   i_req  [N_REQ]          request vector
//   i_ptr  [$clog2(N_REQ)]  index of the last winner
//   o_idx  [$clog2(N_REQ)]  winning index (0 when none)
//   o_any                   at least one request present
module uart_rr_pick #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         i_req,
    input  logic [$clog2(N_REQ)-1:0] i_ptr,
    output logic [$clog2(N_REQ)-1:0] o_idx,
    output logic                     o_any
);

    localparam int unsigned ID_W = $clog2(N_REQ);

    logic [ID_W-1:0] w_cand;

    assign o_any = |i_req;

    // Walk from the farthest offset to the nearest so the nearest hit wins.
    always_comb begin
        o_idx  = '0;
        w_cand = '0;
        for (int unsigned off = N_REQ; off >= 1; off--) begin
            w_cand = ID_W'((32'(i_ptr) + off) % N_REQ);
            if (i_req[w_cand]) begin
                o_idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte-stream requesters with a
// round-robin grant held for a whole message (until the byte flagged last
// has left the line), plus a stall timer that force-releases a silent owner.
// Optional feature macro: UART_ARB_HDR_EN (sends one header byte per grant).
// Ports:
//   clk, resetn                 clock, async active-low reset
//   req_valid/req_last [N_REQ]  per-requester handshake and end-of-message
//   req_data [N_REQ*PB]         packed bytes, requester i at [i*PB +: PB]
//   req_ready [N_REQ]           combinational accept strobe for the owner
//   grant_id, granted           current/last owner, message in progress
//   hold_abort                  one-cycle pulse on forced release
//   uart_tx_en, uart_tx_data    start pulse and byte to the transmitter
//   uart_tx_busy                transmitter busy
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned HOLD_CYCLES  = 1024
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [N_REQ-1:0]                req_valid,
    input  logic [N_REQ*PAYLOAD_BITS-1:0]   req_data,
    input  logic [N_REQ-1:0]                req_last,
    output logic [N_REQ-1:0]                req_ready,
    output logic [$clog2(N_REQ)-1:0]        grant_id,
    output logic                            granted,
    output logic                            hold_abort,
    output logic                            uart_tx_en,
    output logic [PAYLOAD_BITS-1:0]         uart_tx_data,
    input  logic                            uart_tx_busy
);

    localparam int unsigned ID_W    = $clog2(N_REQ);
    localparam int unsigned STALL_W = $clog2(HOLD_CYCLES + 1);

    arb_state_t              r_state;
    logic [ID_W-1:0]         r_ptr;
    logic [ID_W-1:0]         r_grant_id;
    logic                    r_granted;
    logic                    r_hold_abort;
    logic                    r_tx_en;
    logic [PAYLOAD_BITS-1:0] r_tx_data;
    logic                    r_last;
    logic [STALL_W-1:0]      r_stall;

    logic [ID_W-1:0]         w_pick_idx;
    logic                    w_pick_any;
    logic [N_REQ-1:0]        w_ready;
    logic                    w_owner_valid;
    logic                    w_accept;
    logic                    w_stall_hit;
    logic [PAYLOAD_BITS-1:0] w_byte;

    uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    assign w_owner_valid = req_valid[r_grant_id];
    assign w_byte        = PAYLOAD_BITS'(req_slice(MAX_BUS_W'(req_data), 3'(r_grant_id), PAYLOAD_BITS));

    // Only the owner is offered ready, and never while tx is still busy.
    always_comb begin
        w_ready = '0;
        if (r_state == ST_XFER && !uart_tx_busy) begin
            w_ready[r_grant_id] = 1'b1;
        end
    end

    assign w_accept    = w_ready[r_grant_id] & w_owner_valid;
    assign w_stall_hit = (r_state == ST_XFER) && !w_owner_valid &&
                         (r_stall == STALL_W'(HOLD_CYCLES - 1));

    // Grant/handshake FSM with registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_ptr        <= ID_W'(N_REQ - 1);
            r_grant_id   <= '0;
            r_granted    <= 1'b0;
            r_hold_abort <= 1'b0;
            r_tx_en      <= 1'b0;
            r_tx_data    <= '0;
            r_last       <= 1'b0;
            r_stall      <= '0;
        end else begin
            r_tx_en      <= 1'b0;
            r_hold_abort <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        r_grant_id <= w_pick_idx;
                        r_granted  <= 1'b1;
                        r_stall    <= '0;
`ifdef UART_ARB_HDR_EN
                        r_state    <= ST_HDR;
`else
                        r_state    <= ST_XFER;
`endif
                    end
                end
`ifdef UART_ARB_HDR_EN
                ST_HDR: begin
                    if (!uart_tx_busy) begin
                        r_tx_data <= PAYLOAD_BITS'(hdr_byte(3'(r_grant_id)));
                        r_tx_en   <= 1'b1;
                        r_last    <= 1'b0;
                        r_state   <= ST_WAIT_HI;
                    end
                end
`endif
                ST_XFER: begin
                    if (w_accept) begin
                        r_tx_data <= w_byte;
                        r_tx_en   <= 1'b1;
                        r_last    <= req_last[r_grant_id];
                        r_stall   <= '0;
                        r_state   <= ST_WAIT_HI;
                    end else if (!w_owner_valid) begin
                        if (w_stall_hit) begin
                            // Owner went quiet too long: release as if last.
                            r_hold_abort <= 1'b1;
                            r_ptr        <= r_grant_id;
                            r_granted    <= 1'b0;
                            r_stall      <= '0;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_stall <= r_stall + STALL_W'(1);
                        end
                    end
                end
                ST_WAIT_HI: begin
                    if (uart_tx_busy) begin
                        r_state <= ST_WAIT_LO;
                    end
                end
                ST_WAIT_LO: begin
                    if (!uart_tx_busy) begin
                        if (r_last) begin
                            r_ptr     <= r_grant_id;
                            r_granted <= 1'b0;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_state <= ST_XFER;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready    = w_ready;
    assign grant_id     = r_grant_id;
    assign granted      = r_granted;
    assign hold_abort   = r_hold_abort;
    assign uart_tx_en   = r_tx_en;
    assign uart_tx_data = r_tx_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural 12-clocks-per-bit transmitter and
// line receiver, per-requester byte queues, and a scoreboard of expected
// (byte, owner) at each start pulse and expected bytes on the serial line.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned PB    = 8;
    localparam int unsigned HOLD  = 1024;
    localparam int          CPB   = 12;
`ifdef UART_ARB_HDR_EN
    localparam int          HDR_N = 1;
`else
    localparam int          HDR_N = 0;
`endif

    logic               clk = 1'b0;
    logic               resetn;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ*PB-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic [1:0]         grant_id;
    logic               granted;
    logic               hold_abort;
    logic               uart_tx_en;
    logic [PB-1:0]      uart_tx_data;
    logic               uart_tx_busy;
    logic               uart_txd;

    uart_tx_arbiter #(.N_REQ(N_REQ), .PAYLOAD_BITS(PB), .HOLD_CYCLES(HOLD)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .grant_id     (grant_id),
        .granted      (granted),
        .hold_abort   (hold_abort),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_data (uart_tx_data),
        .uart_tx_busy (uart_tx_busy)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy rises the cycle after the pulse, 8N1 frame.
    logic [9:0] tx_sh;
    int         tx_bit;
    int         tx_cnt;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            uart_tx_busy <= 1'b0;
            uart_txd     <= 1'b1;
            tx_sh        <= '1;
            tx_bit       <= 0;
            tx_cnt       <= 0;
        end else if (!uart_tx_busy) begin
            if (uart_tx_en) begin
                uart_tx_busy <= 1'b1;
                tx_sh        <= {1'b1, uart_tx_data, 1'b0};
                uart_txd     <= 1'b0;
                tx_bit       <= 0;
                tx_cnt       <= 0;
            end
        end else if (tx_cnt == CPB - 1) begin
            tx_cnt <= 0;
            if (tx_bit == 9) begin
                uart_tx_busy <= 1'b0;
                uart_txd     <= 1'b1;
            end else begin
                tx_bit   <= tx_bit + 1;
                uart_txd <= tx_sh[tx_bit + 1];
            end
        end else begin
            tx_cnt <= tx_cnt + 1;
        end
    end

    // Counters and scoreboard.
    int n_chk  = 0;
    int n_fail = 0;
    int en_cnt = 0;
    int ab_cnt = 0;
    int cyc    = 0;

    typedef struct packed { logic [7:0] d; logic [1:0] g; } exp_t;
    exp_t       exp_en_q[$];
    logic [7:0] exp_line_q[$];

    typedef struct packed { logic [7:0] data; logic last; } rbyte_t;
    rbyte_t rbuf [N_REQ][64];
    int     rhead [N_REQ];
    int     rtail [N_REQ];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm, input string why);
        n_chk++;
        n_fail++;
        $display("FAIL %s: %s", nm, why);
    endtask

    task automatic expect_byte(input logic [1:0] g, input logic [7:0] d, input bit on_line);
        exp_en_q.push_back('{d: d, g: g});
        if (on_line) exp_line_q.push_back(d);
    endtask

    task automatic expect_grant(input logic [1:0] g);
        if (HDR_N != 0) expect_byte(g, {4'hA, 1'b0, 1'b0, g}, 1'b1);
    endtask

    task automatic load(input int id, input logic [7:0] d, input logic l);
        rbuf[id][rtail[id]] = '{data: d, last: l};
        rtail[id]++;
    endtask

    function automatic bit pending();
        bit p = (exp_en_q.size() != 0) || (exp_line_q.size() != 0);
        for (int i = 0; i < N_REQ; i++) if (rhead[i] != rtail[i]) p = 1'b1;
        return p;
    endfunction

    task automatic wait_idle(input string nm, input int budget);
        int t = 0;
        while ((pending() || granted || uart_tx_busy) && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (t >= budget) fail(nm, "timeout waiting for idle");
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_en(input string nm, input int target, input int budget);
        int t = 0;
        while (en_cnt < target && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (t >= budget) fail(nm, "timeout waiting for start pulse");
    endtask

    // Requester drivers: present queue heads, pop what was accepted.
    initial begin : drv
        logic [N_REQ-1:0] acc;
        acc = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rhead[i] = 0;
            rtail[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < N_REQ; i++) begin
                if (!resetn) rhead[i] = rtail[i];
                else if (acc[i]) rhead[i]++;
                if (rhead[i] != rtail[i]) begin
                    req_valid[i]        = 1'b1;
                    req_data[i*PB +: PB] = rbuf[i][rhead[i]].data;
                    req_last[i]         = rbuf[i][rhead[i]].last;
                end else begin
                    req_valid[i]        = 1'b0;
                    req_data[i*PB +: PB] = '0;
                    req_last[i]         = 1'b0;
                end
            end
            acc = resetn ? (req_valid & req_ready) : '0;
        end
    end

    // Start-pulse monitor.
    initial begin : en_mon
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (hold_abort) ab_cnt++;
            if (resetn && uart_tx_en) begin
                en_cnt++;
                if (exp_en_q.size() == 0) begin
                    fail("en_unexpected", $sformatf("pulse with byte %0h", uart_tx_data));
                end else begin
                    e = exp_en_q.pop_front();
                    chk("en_data", 32'(uart_tx_data), 32'(e.d));
                    chk("en_grant_id", 32'(grant_id), 32'(e.g));
                end
            end
        end
    end

    // Line receiver sampling mid-bit.
    initial begin : rx_mon
        bit         act;
        int         n;
        logic [9:0] sh;
        logic [7:0] e;
        act = 1'b0;
        n   = 0;
        sh  = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                act = 1'b0;
            end else if (!act) begin
                if (uart_txd == 1'b0) begin
                    act = 1'b1;
                    n   = 0;
                end
            end else begin
                n++;
                if (n % CPB == CPB / 2) begin
                    sh = {uart_txd, sh[9:1]};
                    if (n == 9 * CPB + CPB / 2) begin
                        act = 1'b0;
                        chk("line_stop_bit", 32'(sh[9]), 32'd1);
                        if (exp_line_q.size() == 0) begin
                            fail("line_unexpected", $sformatf("byte %0h", sh[8:1]));
                        end else begin
                            e = exp_line_q.pop_front();
                            chk("line_byte", 32'(sh[8:1]), 32'(e));
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct packed { logic [3:0] mask; logic [2:0] n; logic [7:0] ord; } row_t;
    row_t tbl [6];

    initial begin : main
        int base;
        int t;
        int ab0;
        int t_en;
        logic [7:0] o;
        logic [1:0] g;

        // Round-robin table from reset (pointer starts at N_REQ-1).
        tbl[0] = '{mask: 4'b1111, n: 3'd4, ord: {2'd3, 2'd2, 2'd1, 2'd0}};
        tbl[1] = '{mask: 4'b0011, n: 3'd2, ord: {2'd0, 2'd0, 2'd1, 2'd0}};
        tbl[2] = '{mask: 4'b1011, n: 3'd3, ord: {2'd0, 2'd1, 2'd0, 2'd3}};
        tbl[3] = '{mask: 4'b0100, n: 3'd1, ord: {2'd0, 2'd0, 2'd0, 2'd2}};
        tbl[4] = '{mask: 4'b1001, n: 3'd2, ord: {2'd0, 2'd0, 2'd0, 2'd3}};
        tbl[5] = '{mask: 4'b0110, n: 3'd2, ord: {2'd0, 2'd0, 2'd2, 2'd1}};

        resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_granted", 32'(granted), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_hold_abort", 32'(hold_abort), 32'd0);
        chk("rst_tx_en", 32'(uart_tx_en), 32'd0);
        chk("rst_tx_data", 32'(uart_tx_data), 32'd0);
        @(posedge clk) #1 resetn = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_granted", 32'(granted), 32'd0);
        chk("idle_req_ready", 32'(req_ready), 32'd0);

        for (int r = 0; r < 6; r++) begin
            @(posedge clk) #1;
            o = tbl[r].ord;
            for (int k = 0; k < int'(tbl[r].n); k++) begin
                g = o[2*k +: 2];
                expect_grant(g);
                expect_byte(g, 8'h10 + 8'(g), 1'b1);
            end
            for (int i = 0; i < N_REQ; i++)
                if (tbl[r].mask[i]) load(i, 8'h10 + 8'(i), 1'b1);
            wait_idle($sformatf("tbl%0d", r), 3000);
            chk($sformatf("tbl%0d_last_grant", r), 32'(grant_id), 32'(o[2*(int'(tbl[r].n)-1) +: 2]));
        end

        // Three-byte message from requester 0.
        @(posedge clk) #1;
        base = en_cnt;
        expect_grant(2'd0);
        expect_byte(2'd0, 8'h55, 1'b1);
        expect_byte(2'd0, 8'hA3, 1'b1);
        expect_byte(2'd0, 8'h0F, 1'b1);
        load(0, 8'h55, 1'b0);
        load(0, 8'hA3, 1'b0);
        load(0, 8'h0F, 1'b1);
        t = 0;
        while ((en_cnt - base < 3 + HDR_N || granted) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) fail("t1_release", "timeout");
        chk("t1_en_count", 32'(en_cnt - base), 32'(3 + HDR_N));
        chk("t1_line_drained", 32'(exp_line_q.size()), 32'd0);
        chk("t1_busy_at_release", 32'(uart_tx_busy), 32'd0);
        wait_idle("t1", 200);
        chk("t1_en_count_final", 32'(en_cnt - base), 32'(3 + HDR_N));

        // No interleaving: requester 2 waits for requester 1's last byte.
        @(posedge clk) #1;
        base = en_cnt;
        expect_grant(2'd1);
        expect_byte(2'd1, 8'h22, 1'b1);
        load(1, 8'h22, 1'b0);
        wait_en("t3_first", base + 1 + HDR_N, 500);
        @(posedge clk) #1 load(2, 8'h44, 1'b1);
        repeat (300) @(negedge clk);
        chk("t3_still_granted", 32'(granted), 32'd1);
        chk("t3_owner", 32'(grant_id), 32'd1);
        chk("t3_no_extra_pulse", 32'(en_cnt - base), 32'(1 + HDR_N));
        @(posedge clk) #1;
        expect_byte(2'd1, 8'h33, 1'b1);
        expect_grant(2'd2);
        expect_byte(2'd2, 8'h44, 1'b1);
        load(1, 8'h33, 1'b1);
        wait_idle("t3", 2000);

        // Stall timeout after a non-last byte.
        @(posedge clk) #1;
        base = en_cnt;
        ab0  = ab_cnt;
        expect_grant(2'd0);
        expect_byte(2'd0, 8'h01, 1'b1);
        load(0, 8'h01, 1'b0);
        wait_en("t4_first", base + 1 + HDR_N, 500);
        t_en = cyc;
        @(posedge clk) #1;
        expect_grant(2'd3);
        expect_byte(2'd3, 8'h5A, 1'b1);
        load(3, 8'h5A, 1'b1);
        t = 0;
        while (ab_cnt == ab0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) fail("t4_abort", "hold_abort never pulsed");
        if (cyc - t_en < int'(HOLD) + 120 || cyc - t_en > int'(HOLD) + 125)
            fail("t4_abort_time", $sformatf("abort %0d cycles after pulse", cyc - t_en));
        else
            n_chk++;
        chk("t4_released", 32'(granted), 32'd0);
        wait_idle("t4", 1000);
        chk("t4_abort_width", 32'(ab_cnt - ab0), 32'd1);

        // Reset in the middle of the second byte of a four-byte message.
        @(posedge clk) #1;
        base = en_cnt;
        expect_grant(2'd0);
        expect_byte(2'd0, 8'hA1, 1'b1);
        expect_byte(2'd0, 8'hA2, 1'b0);
        load(0, 8'hA1, 1'b0);
        load(0, 8'hA2, 1'b0);
        load(0, 8'hA3, 1'b0);
        load(0, 8'hA4, 1'b1);
        wait_en("t5_second", base + 2 + HDR_N, 1000);
        repeat (30) @(negedge clk);
        chk("t5_busy_before_reset", 32'(uart_tx_busy), 32'd1);
        @(posedge clk) #1 resetn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t5_rst_tx_en", 32'(uart_tx_en), 32'd0);
            chk("t5_rst_req_ready", 32'(req_ready), 32'd0);
            chk("t5_rst_granted", 32'(granted), 32'd0);
            chk("t5_rst_txd", 32'(uart_txd), 32'd1);
        end
        chk("t5_en_q_empty", 32'(exp_en_q.size()), 32'd0);
        chk("t5_line_q_empty", 32'(exp_line_q.size()), 32'd0);
        @(posedge clk) #1 resetn = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk) #1;
        expect_grant(2'd0);
        expect_byte(2'd0, 8'hB0, 1'b1);
        expect_grant(2'd2);
        expect_byte(2'd2, 8'hB2, 1'b1);
        load(2, 8'hB2, 1'b1);
        load(0, 8'hB0, 1'b1);
        wait_idle("t5", 1500);

        // Single byte from requester 2 (preceded by header when enabled).
        @(posedge clk) #1;
        base = en_cnt;
        expect_grant(2'd2);
        expect_byte(2'd2, 8'h7E, 1'b1);
        load(2, 8'h7E, 1'b1);
        wait_idle("t6", 1000);
        chk("t6_en_count", 32'(en_cnt - base), 32'(1 + HDR_N));

        chk("final_en_q", 32'(exp_en_q.size()), 32'd0);
        chk("final_line_q", 32'(exp_line_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
